// File: rtl/me_control_param.sv
// Parametrised motion-estimation controller: sequences the address generators and PE array,
// tracks the minimum SAD with optional early termination and returns the best vector on req/ack.
module me_control_param #(
   parameter int unsigned TB_LENGTH    = 8,
   parameter int unsigned SW_LENGTH    = 32,
   parameter int unsigned SAD_WIDTH    = 16,
   parameter int unsigned PIPE_LATENCY = 32,
   localparam int unsigned N_POS = SW_LENGTH - TB_LENGTH + 1,
   localparam int unsigned VEC_W = (N_POS > 2) ? $clog2(N_POS) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req,
   input  logic                 abort,
   input  logic                 thresh_en,
   input  logic [SAD_WIDTH-1:0] thresh,
   input  logic [SAD_WIDTH-1:0] sad,
   output logic                 clr,
   output logic                 en_addr_sw,
   output logic                 en_addr_tb,
   output logic                 en_pearray_sw,
   output logic                 en_pearray_tb,
   output logic [SAD_WIDTH-1:0] min_sad,
   output logic [2*VEC_W-1:0]   min_mvec,
   output logic                 early,
   output logic                 busy,
   output logic                 ack
);

   localparam int unsigned N_CAND    = N_POS * N_POS;
   localparam int unsigned RUN_END   = PIPE_LATENCY + N_CAND;
   localparam int unsigned SHIFT_END = SW_LENGTH * SW_LENGTH + SW_LENGTH - TB_LENGTH + 1;
   localparam int unsigned CNT_MAX   = (RUN_END > SHIFT_END) ? RUN_END : SHIFT_END;
   localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] C_MAX   = CNT_W'(CNT_MAX);
   localparam logic [CNT_W-1:0] C_SW    = CNT_W'(SW_LENGTH * SW_LENGTH);
   localparam logic [CNT_W-1:0] C_TB    = CNT_W'(TB_LENGTH * TB_LENGTH);
   localparam logic [CNT_W-1:0] C_SHIFT = CNT_W'(SHIFT_END - 1);
   localparam logic [CNT_W-1:0] C_PL    = CNT_W'(PIPE_LATENCY);
   localparam logic [CNT_W-1:0] C_RUN   = CNT_W'(RUN_END);
   localparam logic [VEC_W-1:0] V_LAST  = VEC_W'(N_POS - 1);

   typedef enum logic [2:0] {StInit, StIdle, StRun, StFlush, StAck} state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 flush_q, flush_d;
   logic [VEC_W-1:0]     x_q, x_d, y_q, y_d;
   logic [SAD_WIDTH-1:0] min_sad_q, min_sad_d;
   logic [2*VEC_W-1:0]   min_mvec_q, min_mvec_d;
   logic                 early_q, early_d;
   logic [SAD_WIDTH-1:0] thresh_q, thresh_d;
   logic                 thresh_en_q, thresh_en_d;
   logic                 en_ptb_q;
   logic                 cand_valid, last_cand, better, hit, stream;

   always_comb begin
      cand_valid = (state_q == StRun) && (cnt_q >= C_PL) && (cnt_q < C_RUN);
      last_cand  = cand_valid && (x_q == V_LAST) && (y_q == V_LAST);
      better     = cand_valid && (sad < min_sad_q);
      hit        = cand_valid && thresh_en_q && (sad <= thresh_q);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StInit:  state_d = StIdle;
         StIdle:  if (req) state_d = StRun;
         StRun: begin
            if (abort)          state_d = StIdle;
            else if (hit)       state_d = StAck;
            else if (last_cand) state_d = StFlush;
         end
         StFlush: begin
            if (abort)        state_d = StIdle;
            else if (flush_q) state_d = StAck;
         end
         StAck:   if (!req) state_d = StIdle;
         default: state_d = StInit;
      endcase
   end

   always_comb begin
      cnt_d       = cnt_q;
      flush_d     = 1'b0;
      x_d         = x_q;
      y_d         = y_q;
      min_sad_d   = min_sad_q;
      min_mvec_d  = min_mvec_q;
      early_d     = early_q;
      thresh_d    = thresh_q;
      thresh_en_d = thresh_en_q;

      if (state_q == StIdle || state_q == StInit) cnt_d = '0;
      else if (cnt_q != C_MAX)                    cnt_d = cnt_q + 1'b1;

      if (state_q == StFlush) flush_d = ~flush_q;

      // y is the inner scan loop; the last candidate leaves the counters in place
      if (state_q == StIdle) begin
         x_d = '0;
         y_d = '0;
         if (req) begin
            thresh_d    = thresh;
            thresh_en_d = thresh_en;
         end
      end else if (cand_valid && !last_cand) begin
         if (y_q == V_LAST) begin
            y_d = '0;
            x_d = x_q + 1'b1;
         end else begin
            y_d = y_q + 1'b1;
         end
      end

      if (state_d == StIdle || state_d == StInit) begin
         min_sad_d  = '1;
         min_mvec_d = '0;
         early_d    = 1'b0;
      end else begin
         if (better) begin
            min_sad_d  = sad;
            min_mvec_d = {y_q, x_q};
         end
         if (hit) early_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StInit;
         cnt_q       <= '0;
         flush_q     <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         min_sad_q   <= '1;
         min_mvec_q  <= '0;
         early_q     <= 1'b0;
         thresh_q    <= '0;
         thresh_en_q <= 1'b0;
         en_ptb_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         flush_q     <= flush_d;
         x_q         <= x_d;
         y_q         <= y_d;
         min_sad_q   <= min_sad_d;
         min_mvec_q  <= min_mvec_d;
         early_q     <= early_d;
         thresh_q    <= thresh_d;
         thresh_en_q <= thresh_en_d;
         en_ptb_q    <= en_addr_tb;
      end
   end

   // Window streaming runs to its full length on a normal run, even past ack; early
   // termination and abort cut it off.
   assign stream = (state_q == StRun) || (state_q == StFlush) ||
                   ((state_q == StAck) && !early_q);

   assign en_addr_sw    = stream && (cnt_q < C_SW);
   assign en_addr_tb    = stream && (cnt_q < C_TB);
   assign en_pearray_sw = stream && (cnt_q != '0) && (cnt_q <= C_SHIFT);
   assign en_pearray_tb = en_ptb_q && (state_q == StRun);

   assign clr      = (state_q == StIdle);
   assign busy     = (state_q == StRun) || (state_q == StFlush);
   assign ack      = (state_q == StAck);
   assign min_sad  = min_sad_q;
   assign min_mvec = min_mvec_q;
   assign early    = early_q;

endmodule

// File: doc/me_control_param.md
# me_control_param

Parametrised control unit for the full-search motion-estimation processor. It sequences the search-window and template-block address generators and the PE array, and scans the SAD stream for the minimum. It returns the best motion vector through a req/ack handshake. Beyond the fixed-size controller, it adds generic window/block/SAD sizes, an optional early-termination threshold and a synchronous abort.

## Interface
- TB_LENGTH, 8, template block edge (pixels); ≥2
- SW_LENGTH, 32, search window edge (pixels); > TB_LENGTH
- SAD_WIDTH, 16, SAD width (bits)
- PIPE_LATENCY, 32, cycles from run cycle 0 to the first valid SAD; ≥1
- Derived, not overridable:
  - N_POS = SW_LENGTH-TB_LENGTH+1
  - VEC_W = max(1, $clog2(N_POS))
  - CNT_W: wide enough for max(PIPE_LATENCY+N_POS², SW_LENGTH²+SW_LENGTH-TB_LENGTH+1)

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req  in  1  search request, level
- abort  in  1  synchronous abort, one-cycle pulse or level
- thresh_en  in  1  early-termination enable, sampled at run start
- thresh  in  SAD_WIDTH  early-termination threshold, sampled at run start
- sad  in  SAD_WIDTH  SAD from the PE array adder tree
- clr  out  1  clear datapath accumulators; high in IDLE
- en_addr_sw  out  1  search-window address generator enable
- en_addr_tb  out  1  template address generator enable
- en_pearray_sw  out  1  PE array window shift enable
- en_pearray_tb  out  1  PE array template load enable
- min_sad  out  SAD_WIDTH  best SAD so far
- min_mvec  out  2*VEC_W  best vector {y, x}, each 0..N_POS-1
- early  out  1  last run ended on threshold
- busy  out  1  state is RUN or FLUSH
- ack  out  1  result valid; high in ACK

## Operation
- States: INIT → IDLE → RUN → FLUSH → ACK → IDLE.
- INIT: entered on reset; lasts 1 cycle, then IDLE.
- IDLE:
  - clr=1; min_sad=all-ones, min_mvec=0, early=0.
  - req=1 → RUN; thresh and thresh_en are latched on this edge.
- RUN: a cycle counter c starts at 0 in the first RUN cycle.
  - en_addr_sw=1 for c ∈ [0, SW_LENGTH²-1].
  - en_addr_tb=1 for c ∈ [0, TB_LENGTH²-1].
  - en_pearray_sw=1 for c ∈ [1, SW_LENGTH²+SW_LENGTH-TB_LENGTH].
  - en_pearray_tb = en_addr_tb delayed one cycle; it is 0 in every cycle after leaving RUN.
- Candidate scan: sad is valid at c = PIPE_LATENCY+k, for k = 0..N_POS²-1.
  - x = k / N_POS, y = k mod N_POS (y is the inner loop).
  - Update when sad < min_sad, strictly: min_sad←sad, min_mvec←{y,x}. Ties keep the earlier candidate in scan order.
- Early termination: thresh_en latched=1 and a valid sad ≤ thresh.
  - The min update happens as normal, early←1, state → ACK on the same edge (FLUSH is skipped).
  - All enables are 0 from the next cycle.
- Normal end: after the last candidate (k=N_POS²-1), state → FLUSH for exactly 2 cycles, then ACK.
- ACK:
  - ack=1; min_sad, min_mvec and early are held.
  - req=0 → IDLE.
- abort=1 in RUN or FLUSH:
  - next state IDLE; all enables 0 next cycle; min registers reset by IDLE; no ack.
  - abort is ignored in IDLE, ACK and INIT.
- req deasserted during RUN/FLUSH is ignored; the run completes. req still high in ACK holds ACK.

## Timing
- Reset values: clr=0, all enables 0, min_sad=all-ones, min_mvec=0, early=0, busy=0, ack=0. State INIT.
- Reset mid-run: immediate return to reset values; no partial result survives.
- Stage latencies:
  - req↑ sampled in IDLE → RUN (c=0) on the next edge.
  - sad at cycle t → min_sad/min_mvec updated at t+1.
- Normal run: ack rises at c = PIPE_LATENCY+N_POS²+2. Defaults: c=659.
- Early run: ack rises one cycle after the qualifying sad. At default timing the earliest is c=33.
- After req↓ in ACK: ack=0 and clr=1 on the next edge. The next req is accepted one cycle after that.
- All counters saturate or stop at their end values; no wrap inside a run.

## Test plan
- Default params, thresh_en=0, sad = 1000-k with a floor at 5 from k=995 onward.
  - Required: min_sad=5, min_mvec from k=995 (y=20, x=39 invalid → clamp stimulus so the floor occurs at k=620: y=20, x=24).
  - Required: ack at c=659; en_addr_sw high for exactly 1024 cycles; en_addr_tb high for exactly 64 cycles.
- Tie: sad=100 at k=3 and k=50, all others 200.
  - Required: min_sad=100, min_mvec={y=3, x=0}.
- Early termination: thresh_en=1, thresh=10; sad=9 at k=40, all others 500.
  - Required: ack at c=73; early=1; min_mvec={15,1}; enables 0 from c=73.
- Abort pulse at c=300.
  - Required: busy=0 and clr=1 at c=301; ack never rises; a following req runs normally.
- TB_LENGTH=4, SW_LENGTH=8, PIPE_LATENCY=6: N_POS=5, 25 candidates.
  - Required: ack at c=33; min_mvec width 6.
- Async reset asserted at c=100.
  - Required: all outputs at reset values immediately; INIT then IDLE after release.
